// File: rtl/pwm_ramp_ctrl_if.sv
// rtl/pwm_ramp_ctrl_if.sv - target handshake bundle for the PWM duty ramp controller
interface pwm_ramp_ctrl_if #(
  parameter int RATE_W = 8
);
  logic              tgt_valid;
  logic              tgt_ready;
  logic [7:0]        tgt_duty;
  logic [7:0]        step;
  logic [RATE_W-1:0] rate;

  modport master (
    output tgt_valid,
    output tgt_duty,
    output step,
    output rate,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_duty,
    input  step,
    input  rate,
    output tgt_ready
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - soft-start duty sequencer stepping PWM duty at period boundaries
module pwm_ramp_ctrl #(
  parameter int PCNT_W = 8,
  parameter int RATE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  pwm_ramp_ctrl_if.slave        tgt_if,
  output logic [7:0]            duty,
  output logic                  busy,
  output logic                  done,
  output logic                  period_tick
);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_IDLE   = 2'd1,
    S_RAMP   = 2'd2,
    S_SHUTDN = 2'd3
  } state_t;

  localparam logic [RATE_W-1:0] RATE_ONE = RATE_W'(1);
  localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);

  state_t            state, state_n;
  logic [PCNT_W-1:0] pcnt;
  logic [RATE_W-1:0] rate_cnt, rate_cnt_n;
  logic [RATE_W-1:0] rate_r, rate_n;
  logic [7:0]        step_r, step_n;
  logic [7:0]        tgt_r, tgt_n;
  logic [7:0]        duty_n;
  logic              done_n;
  logic [7:0]        step_tgt;
  logic [8:0]        sum, diff;
  logic [7:0]        stepped;
  logic              rate_last;

  assign tgt_if.tgt_ready = (state == S_IDLE);
  assign busy             = (state == S_RAMP) || (state == S_SHUTDN);
  assign period_tick      = (pcnt == '1);
  assign rate_last        = (rate_cnt == rate_r - RATE_ONE);

  // Free-running period mirror; shares the PWM reset so it stays phase-aligned with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt <= '0;
    else     pcnt <= pcnt + PCNT_ONE;
  end

  // One step toward the active target using a 9-bit intermediate so nothing wraps.
  always_comb begin
    step_tgt = (state == S_SHUTDN) ? 8'd0 : tgt_r;
    sum      = {1'b0, duty} + {1'b0, step_r};
    diff     = {1'b0, duty} - {1'b0, step_r};
    stepped  = step_tgt;
    if (duty < step_tgt) begin
      if (sum < {1'b0, step_tgt}) stepped = sum[7:0];
    end else begin
      if (!diff[8] && (diff[7:0] > step_tgt)) stepped = diff[7:0];
    end
  end

  // Next-state and datapath decisions; enable is checked ahead of the handshake so it wins.
  always_comb begin
    state_n    = state;
    duty_n     = duty;
    done_n     = 1'b0;
    rate_cnt_n = rate_cnt;
    tgt_n      = tgt_r;
    step_n     = step_r;
    rate_n     = rate_r;
    case (state)
      S_OFF: begin
        duty_n = 8'd0;
        if (enable) state_n = S_IDLE;
      end
      S_IDLE: begin
        if (!enable) begin
          state_n = S_SHUTDN;
        end else if (tgt_if.tgt_valid) begin
          tgt_n      = tgt_if.tgt_duty;
          step_n     = (tgt_if.step == 8'd0) ? 8'd1 : tgt_if.step;
          rate_n     = (tgt_if.rate == '0) ? RATE_ONE : tgt_if.rate;
          rate_cnt_n = '0;
          if (tgt_if.tgt_duty == duty) done_n  = 1'b1;
          else                         state_n = S_RAMP;
        end
      end
      S_RAMP: begin
        if (!enable) begin
          state_n = S_SHUTDN;
        end else if (period_tick) begin
          if (rate_last) begin
            rate_cnt_n = '0;
            duty_n     = stepped;
            if (stepped == tgt_r) begin
              state_n = S_IDLE;
              done_n  = 1'b1;
            end
          end else begin
            rate_cnt_n = rate_cnt + RATE_ONE;
          end
        end
      end
      S_SHUTDN: begin
        if (enable) begin
          state_n = S_IDLE;
        end else if (duty == 8'd0) begin
          state_n = S_OFF;
        end else if (period_tick) begin
          if (rate_last) begin
            rate_cnt_n = '0;
            duty_n     = stepped;
            if (stepped == 8'd0) state_n = S_OFF;
          end else begin
            rate_cnt_n = rate_cnt + RATE_ONE;
          end
        end
      end
      default: state_n = S_OFF;
    endcase
  end

  // State and datapath registers; step/rate default to 1 so shutdown works before any load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_OFF;
      duty     <= 8'd0;
      done     <= 1'b0;
      rate_cnt <= '0;
      tgt_r    <= 8'd0;
      step_r   <= 8'd1;
      rate_r   <= RATE_ONE;
    end else begin
      state    <= state_n;
      duty     <= duty_n;
      done     <= done_n;
      rate_cnt <= rate_cnt_n;
      tgt_r    <= tgt_n;
      step_r   <= step_n;
      rate_r   <= rate_n;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - directed self-checking bench for pwm_ramp_ctrl
module tb_pwm_ramp_ctrl;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] duty;
  logic       busy;
  logic       done;
  logic       period_tick;

  int checks   = 0;
  int failures = 0;
  int n;

  pwm_ramp_ctrl_if #(.RATE_W(8)) tif ();

  pwm_ramp_ctrl #(.PCNT_W(8), .RATE_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .tgt_if      (tif.slave),
    .duty        (duty),
    .busy        (busy),
    .done        (done),
    .period_tick (period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until period_tick is high (pcnt==255); returns the number of clocks advanced.
  task automatic wait_pt(output int cnt);
    cnt = 0;
    while (!period_tick && cnt < 2000) begin
      tick();
      cnt++;
    end
    if (!period_tick) check_val("period_tick_timeout", 0, 1);
  endtask

  task automatic handshake(input int t, input int s, input int r);
    tif.tgt_duty  = 8'(t);
    tif.step      = 8'(s);
    tif.rate      = 8'(r);
    tif.tgt_valid = 1'b1;
    tick();
    tif.tgt_valid = 1'b0;
  endtask

  // Wait rate period boundaries; duty must hold until the last one, then equal exp.
  task automatic step_after(input string tag, input int rate, input int prev,
                            input int exp, input int exp_done);
    int c;
    for (int i = 0; i < rate; i++) begin
      wait_pt(c);
      tick();
      if (i < rate - 1) check_val({tag, "_hold"}, duty, prev);
    end
    check_val(tag, duty, exp);
    check_val({tag, "_done"}, done, exp_done);
  endtask

  initial begin
    rst           = 1'b1;
    enable        = 1'b0;
    tif.tgt_valid = 1'b0;
    tif.tgt_duty  = 8'd0;
    tif.step      = 8'd0;
    tif.rate      = 8'd0;

    // T1: reset state, OFF until enable, period_tick spacing
    repeat (3) tick();
    check_val("rst_duty", duty, 0);
    check_val("rst_ready", tif.tgt_ready, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_ptick", period_tick, 0);
    rst = 1'b0;
    tick();
    check_val("off_ready", tif.tgt_ready, 0);
    enable = 1'b1;
    tick();
    check_val("idle_ready", tif.tgt_ready, 1);
    check_val("idle_busy", busy, 0);
    wait_pt(n);
    check_val("first_ptick_gap", n, 253);
    tick();
    check_val("ptick_low", period_tick, 0);
    wait_pt(n);
    check_val("ptick_period", n, 255);

    // T2: 0 -> 100, step 10, rate 1
    handshake(100, 10, 1);
    check_val("t2_ready", tif.tgt_ready, 0);
    check_val("t2_busy", busy, 1);
    for (int k = 1; k <= 10; k++) begin
      wait_pt(n);
      check_val("t2_gap", n, 255);
      tick();
      check_val("t2_duty", duty, 10 * k);
      check_val("t2_done", done, (k == 10) ? 1 : 0);
      if (k < 10) check_val("t2_busy_mid", busy, 1);
    end
    check_val("t2_ready_after", tif.tgt_ready, 1);
    tick();
    check_val("t2_done_pulse", done, 0);

    // T3: 100 -> 3, step 40, rate 2; last step clamps to target
    handshake(3, 40, 2);
    step_after("t3_s1", 2, 100, 60, 0);
    step_after("t3_s2", 2, 60, 20, 0);
    step_after("t3_s3", 2, 20, 3, 1);

    // T4: saturation at the top, step/rate of 0 treated as 1
    handshake(250, 255, 1);
    step_after("t4_up250", 1, 3, 250, 1);
    handshake(255, 200, 1);
    step_after("t4_sat255", 1, 250, 255, 1);
    handshake(100, 255, 1);
    step_after("t4_down100", 1, 255, 100, 1);
    handshake(102, 0, 0);
    step_after("t4_z1", 1, 100, 101, 0);
    step_after("t4_z2", 1, 101, 102, 1);

    // T6: tgt_valid during RAMP is ignored; tgt == duty gives immediate done
    handshake(150, 10, 1);
    tif.tgt_valid = 1'b1;
    tif.tgt_duty  = 8'd7;
    tif.step      = 8'd1;
    step_after("t6_s1", 1, 102, 112, 0);
    step_after("t6_s2", 1, 112, 122, 0);
    tif.tgt_valid = 1'b0;
    step_after("t6_s3", 1, 122, 132, 0);
    step_after("t6_s4", 1, 132, 142, 0);
    step_after("t6_s5", 1, 142, 150, 1);
    handshake(150, 10, 1);
    check_val("t6_eq_done", done, 1);
    check_val("t6_eq_duty", duty, 150);
    check_val("t6_eq_ready", tif.tgt_ready, 1);
    tick();
    check_val("t6_eq_done_clr", done, 0);

    // T5: ramp 0 -> 200, shutdown at 50
    handshake(0, 255, 1);
    step_after("t5_to0", 1, 150, 0, 1);
    handshake(200, 10, 1);
    for (int k = 1; k <= 5; k++) step_after("t5_up", 1, 10 * (k - 1), 10 * k, 0);
    enable = 1'b0;
    tick();
    check_val("t5_sd_busy", busy, 1);
    check_val("t5_sd_ready", tif.tgt_ready, 0);
    for (int k = 4; k >= 0; k--) step_after("t5_down", 1, 10 * (k + 1), 10 * k, 0);
    check_val("t5_off_busy", busy, 0);
    check_val("t5_off_ready", tif.tgt_ready, 0);
    tick();
    check_val("t5_off_done", done, 0);
    enable = 1'b1;
    tick();
    check_val("t5_reenable_ready", tif.tgt_ready, 1);

    // enable drop in the same clk as a handshake: enable wins
    enable        = 1'b0;
    tif.tgt_valid = 1'b1;
    tif.tgt_duty  = 8'd5;
    tick();
    check_val("sim_busy", busy, 1);
    check_val("sim_done", done, 0);
    tick();
    check_val("sim_off_busy", busy, 0);
    check_val("sim_duty", duty, 0);
    tif.tgt_valid = 1'b0;
    enable        = 1'b1;
    tick();
    check_val("sim_ready", tif.tgt_ready, 1);

    // async reset mid-ramp
    handshake(200, 50, 1);
    step_after("rst_ramp", 1, 0, 50, 0);
    #3;
    rst = 1'b1;
    #1;
    check_val("arst_duty", duty, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_ready", tif.tgt_ready, 0);
    check_val("arst_ptick", period_tick, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
